instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the control unit.
- Owns the program counter and issues single-outstanding read requests to instruction memory.
- Buffers fetched 16-bit instructions in a small prefetch FIFO and presents the head entry to the control unit.
- Consumes the control unit's pc_inc / branch_en / pc_offset to advance or redirect the fetch stream, flushing stale entries.

---
 rtl/instr_fetch_unit.sv | 201 ++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, issues single-outstanding
// reads to instruction memory, buffers returned words in a small prefetch
// FIFO and presents the head entry to the control unit. Branches flush the
// FIFO and redirect the fetch stream. A request in flight when a branch hits
// is completed but its data is discarded (S_DROP).
// Optional perf counters (stall_cnt, flush_cnt): define IFU_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instruction,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              pc_inc,
    input  logic              branch_en,
    input  logic [9:0]        pc_offset,
    output logic [1:0]        fetch_state,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              valid_q, valid_d;

    logic [15:0]       fifo_instr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q    [FIFO_DEPTH];

    logic              push, pop, branch;
    logic [CNT_W-1:0]  count_after_pop, count_post;
    logic [PTR_W-1:0]  rd_ptr_pop;
    logic [ADDR_W-1:0] branch_target;

    // Handshake decode shared by the FIFO, head register and FSM.
    always_comb begin
        push            = (state_q == S_REQ) && imem_ack;
        pop             = pc_inc && valid_q;
        branch          = pop && branch_en;
        count_after_pop = count_q - CNT_W'(pop);
        count_post      = count_after_pop + CNT_W'(push);
        rd_ptr_pop      = rd_ptr_q + PTR_W'(pop);
        // Relative to the instruction after the branch; offset is in words.
        branch_target   = pc_out_q + ADDR_W'(2) + ADDR_W'($signed({pc_offset, 1'b0}));
    end

    // FIFO pointer/count update and next head-of-FIFO output values.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = 1'b0;
        if (branch) begin
            // Flush everything, including a word arriving this very cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rd_ptr_d = rd_ptr_pop;
            count_d  = count_post;
            if (count_after_pop != '0) begin
                instr_d  = fifo_instr_q[rd_ptr_pop];
                pc_out_d = fifo_pc_q[rd_ptr_pop];
                valid_d  = 1'b1;
            end else if (push) begin
                // FIFO empty after the pop: the arriving word becomes the head.
                instr_d  = imem_rdata;
                pc_out_d = fetch_pc_q;
                valid_d  = 1'b1;
            end
        end
    end

    // Fetch FSM: decides when to request and where the fetch PC goes next.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (branch) begin
                    fetch_pc_d = branch_target;
                    state_d    = S_REQ;
                end else if (count_post < CNT_W'(FIFO_DEPTH)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (branch) begin
                        fetch_pc_d = branch_target;
                        state_d    = S_REQ;
                    end else begin
                        fetch_pc_d = fetch_pc_q + ADDR_W'(2);
                        state_d    = (count_post < CNT_W'(FIFO_DEPTH)) ? S_REQ : S_IDLE;
                    end
                end else if (branch) begin
                    // Address must stay put until memory answers; park the target.
                    redirect_pc_d = branch_target;
                    state_d       = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    fetch_pc_d = redirect_pc_q;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, PC, FIFO bookkeeping and head-output registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            instr_q       <= '0;
            pc_out_q      <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            valid_q       <= valid_d;
        end
    end

    // NOTE: FIFO storage has no reset; count and pointers alone define the live entries.
    // Prefetch FIFO storage write.
    always_ff @(posedge clk) begin
        if (push && !branch) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    // Saturating perf counters: cycles without a valid head, accepted branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!valid_q && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (branch && (flush_cnt_q != 16'hFFFF))   flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    assign imem_req    = (state_q == S_REQ) || (state_q == S_DROP);
    assign imem_addr   = fetch_pc_q;
    assign fetch_state = state_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign inst_valid  = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. Reference model: the architectural instruction
// stream. Each accepted consume yields the next PC (pc+2, or the branch
// target); memory content is a pure function of address. A memory responder
// with configurable latency and spurious idle acks drives the bus; a negedge
// monitor compares the presented head against the expected-PC queue.
module tb_instr_fetch_unit;

    localparam int          ADDR_W     = 16;
    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam int          FIFO_DEPTH = 2;
`ifdef IFU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instruction;
    logic        inst_valid;
    logic [15:0] pc_out;
    logic        pc_inc;
    logic        branch_en;
    logic [9:0]  pc_offset;
    logic [1:0]  fetch_state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    instr_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .inst_valid (inst_valid),
        .pc_out     (pc_out),
        .pc_inc     (pc_inc),
        .branch_en  (branch_en),
        .pc_offset  (pc_offset),
        .fetch_state(fetch_state),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          failures  = 0;
    logic [15:0] exp_q[$];
    int          flush_exp = 0;
    int          consumed  = 0;
    bit          mon_en    = 1'b0;

    // Responder configuration
    int          max_wait     = 0;
    bit          fixed_wait   = 1'b0;
    bit          idle_ack_all = 1'b0;
    bit          idle_noise   = 1'b0;
    bit          block_en     = 1'b0;
    logic [15:0] block_addr   = 16'h0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h4C4D;
        if (a == 16'h0002) return 16'h5A48;
        return {a[7:0], a[15:8]} ^ 16'h3C96;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive consumer inputs for one cycle; an accepted consume pushes the next expected PC.
    task automatic drive(input bit inc, input bit br, input logic [9:0] off);
        logic [15:0] cur;
        int          delta;
        pc_inc    = inc;
        branch_en = br;
        pc_offset = off;
        if (inc && inst_valid && !rst && exp_q.size() > 0) begin
            cur   = exp_q[exp_q.size()-1];
            delta = br ? (2 + 2 * int'($signed(off))) : 2;
            exp_q.push_back(16'(int'(cur) + delta));
            if (br) flush_exp++;
            consumed++;
        end
        @(posedge clk); #1;
    endtask

    task automatic start_reset();
        rst       = 1'b1;
        pc_inc    = 1'b0;
        branch_en = 1'b0;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        flush_exp = 0;
    endtask

    // Memory responder: reacts 2 time units after each edge so that
    // configuration written by the driver at +1 applies to the same cycle.
    initial begin : responder
        bit busy;
        int wait_left;
        busy       = 1'b0;
        wait_left  = 0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0;
        forever begin
            @(posedge clk); #2;
            if (imem_req) begin
                if (!busy) begin
                    busy      = 1'b1;
                    wait_left = fixed_wait ? 3 : int'($urandom_range(max_wait, 0));
                end
                if (block_en && imem_addr == block_addr) begin
                    imem_ack = 1'b0;
                end else if (wait_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    busy       = 1'b0;
                end else begin
                    imem_ack = 1'b0;
                    wait_left--;
                end
            end else begin
                busy       = 1'b0;
                imem_ack   = idle_ack_all || (idle_noise && $urandom_range(3, 0) == 0);
                imem_rdata = 16'($urandom);
            end
        end
    end

    // Monitor: head-of-FIFO scoreboard, bus-hold rule, stall counter model.
    logic        prev_wait  = 1'b0;
    logic        prev_rst   = 1'b1;
    logic        prev_valid = 1'b0;
    logic [15:0] prev_addr  = 16'h0;
    int          stall_exp  = 0;

    always @(negedge clk) begin
        if (mon_en && !rst && inst_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL head_unexpected: got pc_out %0h expected no valid head", pc_out);
            end else begin
                check("head_pc", pc_out, exp_q[0]);
                check("head_instr", instruction, mem_word(exp_q[0]));
                if (pc_inc) void'(exp_q.pop_front());
            end
        end
        if (mon_en && prev_wait && !prev_rst) begin
            check("req_held", imem_req, 1);
            check("addr_held", imem_addr, prev_addr);
        end
        if (prev_rst) stall_exp = 0;
        else if (!prev_valid && stall_exp < 65535) stall_exp++;
        if (mon_en && PERF) check("stall_cnt", stall_cnt, stall_exp);
        prev_wait  = imem_req && !imem_ack;
        prev_addr  = imem_addr;
        prev_rst   = rst;
        prev_valid = inst_valid;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish within 1000000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        pc_inc       = 1'b0;
        branch_en    = 1'b0;
        pc_offset    = '0;
        idle_ack_all = 1'b1;
        max_wait     = 0;
        start_reset();
        repeat (3) @(posedge clk);
        #1;

        // Reset state with imem_ack tied high.
        check("rst_valid", inst_valid, 0);
        check("rst_instr", instruction, 16'h0);
        check("rst_pc_out", pc_out, 16'h0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_state", fetch_state, 2'd0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        mon_en = 1'b1;

        // First request one cycle after release; first word the cycle after.
        rst = 1'b0;
        drive(0, 0, '0);
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 16'h0000);
        check("first_state", fetch_state, 2'd1);
        check("first_nvalid", inst_valid, 0);
        drive(0, 0, '0);
        check("first_valid", inst_valid, 1);
        check("first_instr", instruction, 16'h4C4D);
        check("first_pc", pc_out, 16'h0000);

        // With no consume, exactly FIFO_DEPTH words are fetched, then idle.
        drive(0, 0, '0);
        check("full_state", fetch_state, 2'd0);
        check("full_req", imem_req, 0);
        drive(0, 0, '0);
        drive(0, 0, '0);
        check("full_hold_req", imem_req, 0);
        check("full_hold_addr", imem_addr, 16'h0004);
        check("full_hold_pc", pc_out, 16'h0000);
        drive(1, 0, '0);
        check("refill_req", imem_req, 1);
        check("refill_addr", imem_addr, 16'h0004);
        check("second_instr", instruction, 16'h5A48);
        check("second_pc", pc_out, 16'h0002);

        // Walk to head pc 0x0010, then branch backwards by one word.
        for (int i = 0; i < 40; i++) begin
            if (inst_valid && pc_out == 16'h0010) break;
            drive(1, 0, '0);
        end
        check("head_at_0010", {15'h0, inst_valid, pc_out}, {15'h0, 1'b1, 16'h0010});
        drive(1, 1, 10'h3FE);
        check("br_flushed", inst_valid, 0);
        check("br_req", imem_req, 1);
        check("br_addr", imem_addr, 16'h000E);
        check("br_flush_cnt", flush_cnt, PERF ? 1 : 0);

        // Branch while the request to 0x0014 is still unanswered.
        block_addr = 16'h0014;
        block_en   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == 16'h0014 && inst_valid) break;
            drive(inst_valid && !imem_req, 0, '0);
        end
        check("pending_0014", {14'h0, imem_req, inst_valid, imem_addr}, {14'h0, 2'b11, 16'h0014});
        drive(1, 1, 10'd5);
        check("drop_state", fetch_state, 2'd2);
        check("drop_req", imem_req, 1);
        check("drop_addr", imem_addr, 16'h0014);
        check("drop_nvalid", inst_valid, 0);
        drive(0, 0, '0);
        drive(0, 0, '0);
        check("drop_wait_state", fetch_state, 2'd2);
        block_en = 1'b0;
        drive(0, 0, '0);
        check("drop_done_state", fetch_state, 2'd1);
        check("drop_done_addr", imem_addr, 16'h001E);
        check("drop_stale_nvalid", inst_valid, 0);
        drive(0, 0, '0);
        check("target_valid", inst_valid, 1);
        check("target_pc", pc_out, 16'h001E);

        // Slow memory: every request answered after three wait cycles.
        idle_ack_all = 1'b0;
        idle_noise   = 1'b1;
        fixed_wait   = 1'b1;
        for (int i = 0; i < 60; i++) drive(1, 0, '0);

        // Reset while a request is being acked in the same cycle.
        fixed_wait = 1'b0;
        max_wait   = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) break;
            drive(0, 0, '0);
        end
        check("pre_rst_req", imem_req, 1);
        start_reset();
        @(posedge clk); #1;
        check("mid_rst_valid", inst_valid, 0);
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_addr", imem_addr, RESET_PC);
        check("mid_rst_state", fetch_state, 2'd0);
        rst = 1'b0;

        // Randomized traffic: variable latency, spurious idle acks, random branches.
        max_wait = 3;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99, 0) < 60, $urandom_range(99, 0) < 15, 10'($urandom));
        end
        pc_inc = 1'b0;
        check("progress", consumed > 300, 1);
        check("end_flush_cnt", flush_cnt, PERF ? flush_exp : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
